rand_share_arbiter: RTL and testbench

//  Shares the single free-running 32-bit rand_gen output between N_REQ consumers
//  (pixel sparkle, colour picker, scroll jitter) in the icefun led-matrix design.

---
 rtl/rand_share_arbiter_pkg.sv | 19 +
 rtl/rand_share_arbiter_if.sv | 32 +++
 rtl/rand_share_arbiter_rr_pick.sv | 40 ++++
 rtl/rand_share_arbiter.sv | 107 ++++++++++
 tb/tb_rand_share_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rand_share_arbiter_pkg.sv
// Shared types and helpers for the random-word sharing arbiter.
// Holds the FSM state encoding and the counter-width helper.
package rand_share_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StHold  = 2'd2
    } arb_state_e;

    // Width of the free-running rand_gen output feeding the arbiter.
    localparam int unsigned RndInWidth = 32;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rand_share_arbiter_if.sv
// Request/grant bus between the random-word consumers and the arbiter.
// The arbiter side is the slave modport; the consumer side is the master modport.
interface rand_share_arbiter_if
    import rand_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32
) ();

    logic [RndInWidth-1:0] rnd_in;
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      gnt;
    logic [WIDTH-1:0]      rnd_out;
    logic                  busy;

    modport slave (
        input  rnd_in,
        input  req,
        output gnt,
        output rnd_out,
        output busy
    );

    modport master (
        output rnd_in,
        output req,
        input  gnt,
        input  rnd_out,
        input  busy
    );

endinterface

// File: rtl/rand_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping from the top requester back to zero.
module rand_share_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    int unsigned ptr;
    int unsigned off;
    int unsigned best;
    int unsigned best_off;

    always_comb begin
        ptr      = 32'(rr_ptr);
        off      = 0;
        best     = 0;
        best_off = N_REQ;
        any      = |req;
        // Distance from the pointer in rotation order; smallest distance wins.
        for (int unsigned j = 0; j < N_REQ; j++) begin
            off = (j >= ptr) ? (j - ptr) : (j + N_REQ - ptr);
            if (req[j] && (off < best_off)) begin
                best     = j;
                best_off = off;
            end
        end
        win_idx = IDX_W'(best);
        win     = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            win[j] = any && (best == j);
        end
    end

endmodule

// File: rtl/rand_share_arbiter.sv
// Round-robin arbiter sharing one free-running random word among N_REQ consumers,
// with a forced idle gap after each grant so consumers never see adjacent LFSR words.
module rand_share_arbiter
    import rand_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GAP   = 4
) (
    input  logic                clk,
    input  logic                rst,
    rand_share_arbiter_if.slave bus
);

    localparam int unsigned IdxW = cnt_width(N_REQ);
    localparam int unsigned GapW = cnt_width(GAP);

    if (N_REQ < 2 || N_REQ > 8) begin : gen_bad_n_req
        $error("rand_share_arbiter: N_REQ must be in 2..8");
    end
    if (WIDTH < 1 || WIDTH > RndInWidth) begin : gen_bad_width
        $error("rand_share_arbiter: WIDTH must be in 1..32");
    end
    if (GAP < 1) begin : gen_bad_gap
        $error("rand_share_arbiter: GAP must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]  win_idx_q, win_idx_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] rnd_out_q, rnd_out_d;

    logic [N_REQ-1:0] pick_win;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;

    rand_share_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_rr_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;
        gap_cnt_d = gap_cnt_q;
        gnt_d     = '0;
        rnd_out_d = rnd_out_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d   = StGrant;
                    gnt_d     = pick_win;
                    win_idx_d = pick_idx;
                    // Only capture point of rnd_in: the word goes out with the grant.
                    rnd_out_d = bus.rnd_in[WIDTH-1:0];
                end
            end
            StGrant: begin
                state_d   = StHold;
                rr_ptr_d  = (win_idx_q == IdxW'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                gap_cnt_d = GapW'(GAP - 1);
            end
            StHold: begin
                if (gap_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            gap_cnt_q <= '0;
            gnt_q     <= '0;
            rnd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_idx_q <= win_idx_d;
            gap_cnt_q <= gap_cnt_d;
            gnt_q     <= gnt_d;
            rnd_out_q <= rnd_out_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rnd_out = rnd_out_q;
    assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Self-checking bench for rand_share_arbiter: directed scenarios plus random traffic,
// every cycle compared against a cycle-number based reference model.
module tb_rand_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int GAP = 4;

    logic clk;
    logic rst;

    rand_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    rand_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .GAP   (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [N-1:0] req_cur;

    // Reference model: a grant may be decided at the end of cycle c only if
    // c >= last_grant + GAP + 1; the word delivered is the cycle number c.
    bit           m_have;
    int           m_last;
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_rnd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] rq, input int c);
        bit found;
        int w;
        m_gnt = '0;
        if (r) begin
            m_have = 0;
            m_ptr  = 0;
            m_rnd  = '0;
        end else if ((!m_have || c >= m_last + GAP + 1) && rq != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!found && rq[w]) begin
                    found    = 1;
                    m_gnt[w] = 1'b1;
                    m_ptr    = (w + 1) % N;
                end
            end
            m_have = 1;
            m_last = c + 1;
            m_rnd  = W'(c);
        end
    endtask

    // One clock: drive inputs for cycle cyc, advance, check the new cycle's outputs.
    task automatic tick(input logic r);
        logic exp_busy;
        rst        = r;
        bus.req    = req_cur;
        bus.rnd_in = 32'(cyc);
        @(posedge clk);
        model_step(r, req_cur, cyc);
        cyc++;
        #1;
        exp_busy = m_have && (cyc >= m_last) && (cyc - m_last <= GAP);
        check_eq("gnt", 64'(bus.gnt), 64'(m_gnt));
        check_eq("rnd_out", 64'(bus.rnd_out), 64'(m_rnd));
        check_eq("busy", 64'(bus.busy), 64'(exp_busy));
        check_eq("onehot0", 64'($onehot0(bus.gnt)), 64'd1);
        // Consumers drop their request once served.
        req_cur = req_cur & ~bus.gnt;
    endtask

    task automatic wait_gnt(input int max_cycles);
        int k;
        k = 0;
        while (bus.gnt == '0 && k < max_cycles) begin
            tick(1'b0);
            k++;
        end
        if (bus.gnt == '0) check_eq("gnt_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [N-1:0] exp_order [5];
        int gcount;
        int prev;
        int g0;
        int n3;

        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        m_have  = 0;
        m_last  = 0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_rnd   = '0;
        rst     = 1'b1;
        req_cur = '1;
        bus.req = '1;
        bus.rnd_in = '0;

        // Reset held three cycles with all requests high.
        for (int k = 0; k < 3; k++) begin
            req_cur = '1;
            tick(1'b1);
            check_eq("reset_gnt", 64'(bus.gnt), 64'd0);
        end

        // Single request at cycle 10.
        req_cur = '0;
        while (cyc < 10) tick(1'b0);
        req_cur = 4'b0100;
        tick(1'b0);
        check_eq("single_gnt", 64'(bus.gnt), 64'h4);
        check_eq("single_rnd", 64'(bus.rnd_out), 64'd10);
        while (cyc < 16) tick(1'b0);
        check_eq("single_busy_end", 64'(bus.busy), 64'd0);

        // All requests held: strict rotation, GAP+2 spacing.
        req_cur = '1;
        tick(1'b1);
        gcount = 0;
        prev   = -1;
        for (int k = 0; k < 40 && gcount < 5; k++) begin
            req_cur = '1;
            tick(1'b0);
            if (bus.gnt != '0) begin
                check_eq("rr_order", 64'(bus.gnt), 64'(exp_order[gcount]));
                if (prev >= 0) check_eq("rr_spacing", 64'(cyc - prev), 64'(GAP + 2));
                prev = cyc;
                gcount++;
            end
        end
        check_eq("rr_count", 64'(gcount), 64'd5);

        // Request raised mid-HOLD waits for the next IDLE decision.
        req_cur = '0;
        tick(1'b1);
        req_cur = 4'b0001;
        wait_gnt(10);
        g0 = cyc;
        tick(1'b0);
        tick(1'b0);
        req_cur = 4'b0010;
        wait_gnt(12);
        check_eq("hold_gnt", 64'(bus.gnt), 64'h2);
        check_eq("hold_delay", 64'(cyc - g0), 64'(GAP + 2));

        // One-cycle pulse in HOLD is never granted.
        tick(1'b0);
        req_cur = 4'b1000;
        tick(1'b0);
        req_cur = '0;
        n3 = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0);
            if (bus.gnt[3]) n3++;
        end
        check_eq("pulse_never", 64'(n3), 64'd0);

        // Reset during GRANT aborts and re-centres the pointer.
        req_cur = 4'b1000;
        wait_gnt(10);
        tick(1'b1);
        check_eq("abort_gnt", 64'(bus.gnt), 64'd0);
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        req_cur = 4'b1010;
        tick(1'b0);
        check_eq("abort_regnt", 64'(bus.gnt), 64'h2);

        // Random traffic with occasional resets and withdrawals.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_cur[i] && $urandom_range(7) == 0) req_cur[i] = 1'b1;
                else if (req_cur[i] && $urandom_range(31) == 0) req_cur[i] = 1'b0;
            end
            tick($urandom_range(63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
